// File: rtl/mdu_controller.sv
// mdu_controller: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO for the EX stage
// Ports: clk, reset (sync, active-high); Start/MduOp/SrcA/SrcB launch an op in IDLE/DONE;
//        HiWrite/LoWrite/WriteData service MTHI/MTLO; Busy stalls the pipe in CALC/FIXUP;
//        Done pulses one cycle when HI/LO hold a new result; Hi/Lo are the HI/LO registers.
// Optional: MDU_DIV_ZERO_FLAG_EN adds DivZero, set on a divide-by-zero launch until the next launch.
module mdu_controller #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       MduOp,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             HiWrite,
    input  logic             LoWrite,
    input  logic [WIDTH-1:0] WriteData,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
`ifdef MDU_DIV_ZERO_FLAG_EN
    ,
    output logic             DivZero
`endif
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;
    state_t r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic             r_is_div, r_neg_res, r_neg_rem, r_divz;
    logic [WIDTH-1:0] r_opnd, r_acc_hi, r_acc_lo, r_hi, r_lo;
    logic             w_open, w_accept, w_div_zero, w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_mag_a, w_mag_b, w_step_hi, w_step_lo, w_res_hi, w_res_lo;
    logic [WIDTH:0]   w_mul_sum, w_div_shift, w_div_diff;
    logic [2*WIDTH-1:0] w_prod_neg;
    assign w_open     = r_state == S_IDLE || r_state == S_DONE;
    assign w_accept   = Start && w_open;
    assign w_div_zero = MduOp[1] && SrcB == '0;
    // MduOp[0] low selects the signed variants
    assign w_a_neg    = ~MduOp[0] & SrcA[WIDTH-1];
    assign w_b_neg    = ~MduOp[0] & SrcB[WIDTH-1];
    assign w_mag_a    = w_a_neg ? -SrcA : SrcA;
    assign w_mag_b    = w_b_neg ? -SrcB : SrcB;
    // Multiply: {acc_hi, acc_lo} holds partial product over the multiplier; add then shift right.
    assign w_mul_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);
    // Divide: shift remainder left pulling in the next dividend bit, restore on borrow.
    assign w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
    assign w_step_hi   = r_is_div ? (w_div_diff[WIDTH] ? w_div_shift[WIDTH-1:0] : w_div_diff[WIDTH-1:0])
                                  : w_mul_sum[WIDTH:1];
    assign w_step_lo   = r_is_div ? {r_acc_lo[WIDTH-2:0], ~w_div_diff[WIDTH]}
                                  : {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
    assign w_prod_neg  = -{r_acc_hi, r_acc_lo};
    // Divide-by-zero preloads the raw result into the accumulators and bypasses correction.
    assign w_res_hi = r_divz   ? r_acc_hi :
                      r_is_div ? (r_neg_rem ? -r_acc_hi : r_acc_hi) :
                      (r_neg_res ? w_prod_neg[2*WIDTH-1:WIDTH] : r_acc_hi);
    assign w_res_lo = r_divz   ? r_acc_lo :
                      r_is_div ? (r_neg_res ? -r_acc_lo : r_acc_lo) :
                      (r_neg_res ? w_prod_neg[WIDTH-1:0] : r_acc_lo);
    assign Hi = r_hi;
    assign Lo = r_lo;
`ifdef MDU_DIV_ZERO_FLAG_EN
    // r_divz is already latched per launch, which gives the sticky-until-next-Start behaviour
    assign DivZero = r_divz;
`endif
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        Busy   = 1'b0;
        Done   = 1'b0;
        case (r_state)
            S_IDLE:  w_next = Start ? (w_div_zero ? S_FIXUP : S_CALC) : S_IDLE;
            S_CALC: begin
                Busy   = 1'b1;
                w_next = r_cnt == CW'(WIDTH - 1) ? S_FIXUP : S_CALC;
            end
            S_FIXUP: begin
                Busy   = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                Done   = 1'b1;
                w_next = Start ? (w_div_zero ? S_FIXUP : S_CALC) : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_divz    <= 1'b0;
            r_opnd    <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            if (w_accept) begin
                r_cnt     <= '0;
                r_is_div  <= MduOp[1];
                r_neg_res <= w_a_neg ^ w_b_neg;
                r_neg_rem <= w_a_neg;
                r_divz    <= w_div_zero;
                r_opnd    <= MduOp[1] ? w_mag_b : w_mag_a;
                r_acc_hi  <= w_div_zero ? SrcA : '0;
                r_acc_lo  <= w_div_zero ? '1 : (MduOp[1] ? w_mag_a : w_mag_b);
            end else if (r_state == S_CALC) begin
                r_cnt    <= r_cnt + 1'b1;
                r_acc_hi <= w_step_hi;
                r_acc_lo <= w_step_lo;
            end
            if (r_state == S_FIXUP) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else if (w_open) begin
                if (HiWrite) r_hi <= WriteData;
                if (LoWrite) r_lo <= WriteData;
            end
        end
    end
endmodule

// File: tb/tb_mdu_controller.sv
// tb_mdu_controller: directed self-checking bench for mdu_controller
module tb_mdu_controller;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Start = 1'b0;
    logic [1:0]  MduOp = 2'b00;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic        HiWrite = 1'b0;
    logic        LoWrite = 1'b0;
    logic [31:0] WriteData = '0;
    logic        Busy, Done;
    logic [31:0] Hi, Lo;
`ifdef MDU_DIV_ZERO_FLAG_EN
    logic        DivZero;
`endif
    int checks = 0;
    int failures = 0;
    mdu_controller #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MduOp(MduOp), .SrcA(SrcA), .SrcB(SrcB),
        .HiWrite(HiWrite), .LoWrite(LoWrite), .WriteData(WriteData),
        .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
`ifdef MDU_DIV_ZERO_FLAG_EN
        , .DivZero(DivZero)
`endif
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask
    // called at a negedge; leaves the bench at the negedge of the first cycle after the launch edge
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        MduOp = op;
        SrcA  = a;
        SrcB  = b;
        @(negedge clk);
        Start = 1'b0;
    endtask
    // n = cycle index (1 = first cycle after launch) at which Done is seen; busy = Busy cycles seen
    task automatic wait_done(output int n, output int busy);
        n = 1;
        busy = Busy ? 1 : 0;
        while (!Done && n < 100) begin
            @(negedge clk);
            n++;
            if (Busy) busy++;
        end
    endtask
    task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input logic [31:0] eh, input logic [31:0] el);
        int n, busy;
        @(negedge clk);
        issue(op, a, b);
        wait_done(n, busy);
        check({tag, "_lat"}, n, lat);
        check({tag, "_busy"}, busy, lat - 1);
        check({tag, "_hi"}, Hi, eh);
        check({tag, "_lo"}, Lo, el);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, Done}, 32'd0);
    endtask
    initial begin
        int n, busy, dones;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", {31'd0, Busy}, 0);
        check("rst_done", {31'd0, Done}, 0);
        check("rst_hi", Hi, 0);
        check("rst_lo", Lo, 0);
`ifdef MDU_DIV_ZERO_FLAG_EN
        check("rst_divzero", {31'd0, DivZero}, 0);
`endif
        run("multu_ff_x2", 2'b01, 32'hFFFFFFFF, 32'h00000002, 34, 32'h00000001, 32'hFFFFFFFE);
        run("mult_m1_m3", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFD, 34, 32'h00000000, 32'h00000003);
        run("mult_m7_3", 2'b00, 32'hFFFFFFF9, 32'h00000003, 34, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run("div_m7_2", 2'b10, 32'hFFFFFFF9, 32'h00000002, 34, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run("div_7_m2", 2'b10, 32'h00000007, 32'hFFFFFFFE, 34, 32'h00000001, 32'hFFFFFFFD);
        run("divu_100_7", 2'b11, 32'd100, 32'd7, 34, 32'd2, 32'd14);
        run("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 34, 32'h00000000, 32'h80000000);
        run("divu_zero", 2'b11, 32'h12345678, 32'h00000000, 2, 32'h12345678, 32'hFFFFFFFF);
`ifdef MDU_DIV_ZERO_FLAG_EN
        check("divzero_set", {31'd0, DivZero}, 1);
`endif
        // ignored Start and MTHI while busy
        @(negedge clk);
        issue(2'b01, 32'd3, 32'd5);
`ifdef MDU_DIV_ZERO_FLAG_EN
        check("divzero_clr", {31'd0, DivZero}, 0);
`endif
        repeat (9) @(negedge clk);
        Start = 1'b1; MduOp = 2'b11; SrcA = 32'd50; SrcB = 32'd0;
        HiWrite = 1'b1; WriteData = 32'hDEADBEEF;
        @(negedge clk);
        Start = 1'b0; HiWrite = 1'b0;
        wait_done(n, busy);
        check("ign_lat", n + 10, 34);
        check("ign_hi", Hi, 32'd0);
        check("ign_lo", Lo, 32'd15);
        // MTLO then MTHI in idle
        @(negedge clk);
        LoWrite = 1'b1; WriteData = 32'hCAFEF00D;
        @(negedge clk);
        LoWrite = 1'b0;
        check("mtlo_lo", Lo, 32'hCAFEF00D);
        check("mtlo_hi", Hi, 32'd0);
        HiWrite = 1'b1; WriteData = 32'h11112222;
        @(negedge clk);
        HiWrite = 1'b0;
        check("mthi_hi", Hi, 32'h11112222);
        check("mthi_lo", Lo, 32'hCAFEF00D);
        // back-to-back launch from DONE
        @(negedge clk);
        issue(2'b01, 32'd6, 32'd7);
        wait_done(n, busy);
        check("b2b1_lat", n, 34);
        check("b2b1_lo", Lo, 32'd42);
        issue(2'b11, 32'd100, 32'd7);
        check("b2b_done_pulse", {31'd0, Done}, 0);
        check("b2b_busy", {31'd0, Busy}, 1);
        wait_done(n, busy);
        check("b2b2_lat", n, 34);
        check("b2b2_hi", Hi, 32'd2);
        check("b2b2_lo", Lo, 32'd14);
        // reset mid-divide
        @(negedge clk);
        issue(2'b10, 32'd1000, 32'd3);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rmid_busy", {31'd0, Busy}, 0);
        check("rmid_done", {31'd0, Done}, 0);
        check("rmid_hi", Hi, 0);
        check("rmid_lo", Lo, 0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (Done || Busy) dones++;
        end
        check("rmid_no_done", dones, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
